// File: rtl/vsm_program_memory_if.sv
// Bus bundle between the host loader / processor and the program memory.
// The signal names match the program memory's port list one for one.
interface vsm_program_memory_if #(
  parameter int AW = 4
);

  logic          LoadStart;
  logic          LoadValid;
  logic [3:0]    LoadNibble;
  logic          LoadLast;
  logic          LoadReady;
  logic [AW-1:0] Addr;
  logic          ReadEn;
  logic [3:0]    IB;
  logic          IBDrive;
  logic          ProcHold;
  logic [AW:0]   WordCount;

  // Host and processor side: drives download and fetch requests.
  modport master (
    output LoadStart,
    output LoadValid,
    output LoadNibble,
    output LoadLast,
    output Addr,
    output ReadEn,
    input  LoadReady,
    input  IB,
    input  IBDrive,
    input  ProcHold,
    input  WordCount
  );

  // Program memory side.
  modport slave (
    input  LoadStart,
    input  LoadValid,
    input  LoadNibble,
    input  LoadLast,
    input  Addr,
    input  ReadEn,
    output LoadReady,
    output IB,
    output IBDrive,
    output ProcHold,
    output WordCount
  );

endinterface

// File: rtl/vsm_program_memory.sv
// Program memory for the VSM processor: a host downloads 4-bit words while
// the processor is held, then the processor fetches them with one-cycle
// latency. Every output comes straight from a flop, so Addr never reaches IB
// combinationally.
module vsm_program_memory #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic                 MainClock,
  input logic                 MainClear,
  vsm_program_memory_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] LastIndex = (AW+1)'(DEPTH - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_mem [DEPTH];
  logic [AW:0] r_wordCount;
  logic [3:0]  r_ib;
  logic        r_ibDrive;
  logic        r_loadReady;
  logic        r_procHold;

  logic        w_clearMem;
  logic        w_writeEn;
  logic        w_fetch;
  logic        w_addrInRange;

  // Addresses at or beyond the loaded length read as Nop.
  assign w_addrInRange = ({1'b0, bus.Addr} < r_wordCount);

  // State register; reset parks the block in IDLE with the processor held.
  always_ff @(posedge MainClock or posedge MainClear) begin
    if (MainClear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the strobes that drive the memory and fetch path.
  always_comb begin
    w_nextState = r_state;
    w_clearMem  = 1'b0;
    w_writeEn   = 1'b0;
    w_fetch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.LoadStart) begin
          w_nextState = LOAD;
          w_clearMem  = 1'b1;
        end
      end
      LOAD: begin
        if (bus.LoadValid && (r_wordCount != FullCount)) begin
          w_writeEn = 1'b1;
          if (bus.LoadLast || (r_wordCount == LastIndex)) begin
            w_nextState = RUN;
          end
        end
      end
      RUN: begin
        if (bus.LoadStart) begin
          w_nextState = LOAD;
          w_clearMem  = 1'b1;
        end else if (bus.ReadEn) begin
          w_fetch = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Program storage and its fill counter; a new download wipes old words.
  always_ff @(posedge MainClock or posedge MainClear) begin
    if (MainClear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 4'h0;
      end
      r_wordCount <= '0;
    end else if (w_clearMem) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 4'h0;
      end
      r_wordCount <= '0;
    end else if (w_writeEn) begin
      r_mem[r_wordCount[AW-1:0]] <= bus.LoadNibble;
      r_wordCount                <= r_wordCount + 1'b1;
    end
  end

  // Fetch register: one word per accepted ReadEn, Nop on the bus otherwise.
  always_ff @(posedge MainClock or posedge MainClear) begin
    if (MainClear) begin
      r_ib      <= 4'h0;
      r_ibDrive <= 1'b0;
    end else if (w_fetch) begin
      r_ib      <= w_addrInRange ? r_mem[bus.Addr] : 4'h0;
      r_ibDrive <= 1'b1;
    end else begin
      r_ib      <= 4'h0;
      r_ibDrive <= 1'b0;
    end
  end

  // Handshake flags follow the state being entered so they change on the same edge.
  always_ff @(posedge MainClock or posedge MainClear) begin
    if (MainClear) begin
      r_loadReady <= 1'b0;
      r_procHold  <= 1'b1;
    end else begin
      r_loadReady <= (w_nextState == LOAD);
      r_procHold  <= (w_nextState != RUN);
    end
  end

  assign bus.LoadReady = r_loadReady;
  assign bus.ProcHold  = r_procHold;
  assign bus.IB        = r_ib;
  assign bus.IBDrive   = r_ibDrive;
  assign bus.WordCount = r_wordCount;

endmodule

// File: doc/vsm_program_memory.md
VSM_PROGRAM_MEMORY -- requirements
Module: vsm_program_memory

Interface
REQ-001 SHALL provide parameter DEPTH, default 16; number of 4-bit program words, power of two, minimum 2.
REQ-002 SHALL provide parameter AW, default 4; address width, equal to log2(DEPTH).
REQ-003 SHALL provide port MainClock, input, 1 bit; the single clock, rising-edge active.
REQ-004 SHALL provide port MainClear, input, 1 bit; reset, asynchronous, active-high.
REQ-005 SHALL provide port LoadStart, input, 1 bit; one-cycle request to begin a program download.
REQ-006 SHALL provide port LoadValid, input, 1 bit; LoadNibble holds a valid word.
REQ-007 SHALL provide port LoadNibble, input, 4 bits; program word from the host.
REQ-008 SHALL provide port LoadLast, input, 1 bit; qualified by LoadValid, marks the final word.
REQ-009 SHALL provide port LoadReady, output, 1 bit; block accepts a word this cycle.
REQ-010 SHALL provide port Addr, input, AW bits; fetch address from the processor program counter.
REQ-011 SHALL provide port ReadEn, input, 1 bit; fetch request from the processor.
REQ-012 SHALL provide port IB, output, 4 bits; fetched word, driven onto the processor instruction bus.
REQ-013 SHALL provide port IBDrive, output, 1 bit; IB is valid and the bus driver is enabled.
REQ-014 SHALL provide port ProcHold, output, 1 bit; processor is held while 1.
REQ-015 SHALL provide port WordCount, output, AW+1 bits; number of words loaded.

Function
REQ-016 SHALL implement three states: IDLE, LOAD, RUN.
REQ-017 In IDLE: SHALL hold ProcHold=1 and LoadReady=0; on LoadStart=1, SHALL go to LOAD, set WordCount=0, and clear all words to 0000 (Nop).
REQ-018 In LOAD: SHALL hold LoadReady=1 and ProcHold=1; each cycle with LoadValid=1, SHALL write LoadNibble to word[WordCount] and increment WordCount.
REQ-019 In LOAD: a write with LoadLast=1 SHALL move the block to RUN on the same edge.
REQ-020 In LOAD: the write that makes WordCount=DEPTH SHALL move the block to RUN even if LoadLast=0. No further write is possible; WordCount saturates at DEPTH.
REQ-021 In LOAD: LoadValid=0 SHALL leave the state and memory unchanged (stall). LoadStart SHALL be ignored.
REQ-022 In RUN: SHALL hold ProcHold=0 and LoadReady=0.
REQ-023 In RUN: ReadEn=1 at edge N SHALL register the word at Addr, which SHALL appear on IB with IBDrive=1 during cycle N+1 (latency 1).
REQ-024 IBDrive SHALL be 1 for exactly one cycle per accepted ReadEn. Back-to-back ReadEn SHALL give one word per cycle.
REQ-025 A fetch with Addr >= WordCount SHALL return 0000 (Nop).
REQ-026 IB SHALL be 0000 whenever IBDrive=0.
REQ-027 ReadEn outside RUN SHALL be ignored: IBDrive stays 0.
REQ-028 LoadStart=1 in RUN SHALL move the block to LOAD, set WordCount=0, and clear memory. A simultaneous ReadEn SHALL be dropped, and IBDrive SHALL be 0 in the next cycle.
REQ-029 LoadValid, LoadNibble and LoadLast SHALL be ignored outside LOAD.
REQ-030 Memory, state and outputs SHALL be flops only. No combinational path from Addr to IB is allowed.

Reset
REQ-031 MainClear=1 SHALL immediately force state IDLE, all words 0000, WordCount=0, IB=0000, IBDrive=0, LoadReady=0, ProcHold=1.
REQ-032 Asserting MainClear mid-LOAD or mid-fetch SHALL discard the partial program and any in-flight read.
REQ-033 Operation SHALL resume on the first rising MainClock after MainClear falls.

Verification
REQ-034 Load 0101,0001,0011 with LoadLast on the third word, then ReadEn at Addr 0..3 -> IB 0101, 0001, 0011, 0000 on consecutive cycles, IBDrive=1 each cycle, WordCount=3.
REQ-035 Load DEPTH words with LoadLast=0 -> RUN entered after word 16, WordCount=16, ProcHold falls the next cycle; a 17th LoadValid is not written.
REQ-036 LoadValid toggling 1,0,0,1 during LOAD -> exactly 2 words written; LoadReady stays 1 throughout.
REQ-037 In RUN, LoadStart and ReadEn asserted in the same cycle -> IBDrive=0 next cycle, state LOAD, ProcHold=1, all reads return 0000 after reload with zero words.
REQ-038 MainClear pulsed asynchronously between edges mid-LOAD -> outputs reach reset values before the next edge; the prior words read back as 0000 after a new 1-word load.
REQ-039 ReadEn=1 while in IDLE or LOAD -> IBDrive remains 0, IB remains 0000.
